// File: rtl/divide_shift_sub_pkg.sv
// Shared definitions for the shift-subtract divider: FSM state encoding and
// the quotient pattern reported on divide-by-zero.
package divide_shift_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Wide enough for any practical operand width; users slice the low n bits.
  localparam int              MAX_W      = 64;
  localparam logic [MAX_W-1:0] Q_ALL_ONES = '1;

endpackage

// File: rtl/divide_shift_sub_if.sv
// Request/result bundle of the divider: start with operands in, quotient,
// remainder and status out.
interface divide_shift_sub_if #(parameter int n = 4);

  logic         start;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic [n-1:0] Q;
  logic [n-1:0] R;
  logic         busy;
  logic         done;
  logic         dbz;

  modport master (output start, A, B, input Q, R, busy, done, dbz);
  modport slave  (input start, A, B, output Q, R, busy, done, dbz);

endinterface

// File: rtl/divide_shift_sub_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare
// against the divisor and subtract when it fits.
module div_step #(
  parameter int n = 4
) (
  input  logic [n:0]   partial,
  input  logic         msb,
  input  logic [n-1:0] divisor,
  output logic [n:0]   partial_nxt,
  output logic         qbit
);

  logic [n:0] shifted;
  logic [n:0] dvs_ext;
  logic       unused_partial_top;

  // The top bit is always zero after a restoring step, so it is shifted out.
  assign unused_partial_top = partial[n];
  assign shifted            = {partial[n-1:0], msb};
  assign dvs_ext            = {1'b0, divisor};
  assign qbit               = (shifted >= dvs_ext);
  assign partial_nxt        = qbit ? (shifted - dvs_ext) : shifted;

endmodule

// File: rtl/divide_shift_sub.sv
// Iterative unsigned divider, one quotient bit per clock, MSB first, with
// back-to-back acceptance from DONE and a one-cycle divide-by-zero path.
module divide_shift_sub
  import divide_shift_sub_pkg::*;
#(
  parameter int n = 4
) (
  input  logic              clk,
  input  logic              rst,
  divide_shift_sub_if.slave bus
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  state_t       state;
  logic [n:0]   part;
  logic [n-1:0] dvd;
  logic [n-1:0] dvs;
  logic [CW-1:0] cnt;
  logic [n-1:0] q_r;
  logic [n-1:0] r_r;
  logic         dbz_r;

  logic [n:0]   part_nxt;
  logic         qbit;
  logic         accept;

  div_step #(.n(n)) u_step (
    .partial     (part),
    .msb         (dvd[n-1]),
    .divisor     (dvs),
    .partial_nxt (part_nxt),
    .qbit        (qbit)
  );

  assign accept = bus.start && (state != ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      part  <= '0;
      dvd   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dbz_r <= 1'b0;
    end else if (state == ST_RUN) begin
      // Dividend bits leave at the top while quotient bits fill in at the bottom.
      part <= part_nxt;
      dvd  <= {dvd[n-2:0], qbit};
      cnt  <= cnt - 1'b1;
      if (cnt == '0) begin
        state <= ST_DONE;
        q_r   <= {dvd[n-2:0], qbit};
        r_r   <= part_nxt[n-1:0];
        dbz_r <= 1'b0;
      end
    end else if (accept) begin
      if (bus.B == '0) begin
        state <= ST_DONE;
        q_r   <= Q_ALL_ONES[n-1:0];
        r_r   <= bus.A;
        dbz_r <= 1'b1;
      end else begin
        state <= ST_RUN;
        dvd   <= bus.A;
        dvs   <= bus.B;
        part  <= '0;
        cnt   <= CW'(n - 1);
      end
    end else begin
      state <= ST_IDLE;
    end
  end

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.Q    = q_r;
  assign bus.R    = r_r;
  assign bus.dbz  = dbz_r;

endmodule

// File: tb/tb_divide_shift_sub.sv
// Bench for divide_shift_sub: directed vector table, hand-built corner
// sequences and all 256 operand pairs in shuffled order against a model.
module tb_divide_shift_sub;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   ncmp  = 0;
  int   nfail = 0;

  divide_shift_sub_if #(.n(N)) bus ();

  divide_shift_sub #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  task automatic model(input int a, input int b, output int q, output int r, output int z);
    z = (b == 0) ? 1 : 0;
    q = (b == 0) ? 15 : a / b;
    r = (b == 0) ? a : a % b;
  endtask

  // Counts from the current negedge (i=1) until done is seen; flags any
  // change of the held results while waiting.
  task automatic wait_done(input logic [3:0] hq, input logic [3:0] hr, input logic hz,
                           output int lat, output int nbusy, output int bad);
    lat = -1; nbusy = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) nbusy++;
      if (bus.Q != hq || bus.R != hr || bus.dbz != hz) bad = 1;
      @(negedge clk);
    end
  endtask

  // Called on a negedge; start is pulsed for one clock.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output int nbusy, output int bad);
    logic [3:0] hq, hr;
    logic       hz;
    hq = bus.Q; hr = bus.R; hz = bus.dbz;
    bus.start = 1'b1; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(hq, hr, hz, lat, nbusy, bad);
  endtask

  task automatic run_check(input string tag, input logic [3:0] a, input logic [3:0] b);
    int lat, nbusy, bad, eq, er, ez;
    model(a, b, eq, er, ez);
    run_op(a, b, lat, nbusy, bad);
    chk({tag, "_lat"},  lat,           (b == 0) ? 1 : 5);
    chk({tag, "_busy"}, nbusy,         (b == 0) ? 0 : 4);
    chk({tag, "_hold"}, bad,           0);
    chk({tag, "_q"},    int'(bus.Q),   eq);
    chk({tag, "_r"},    int'(bus.R),   er);
    chk({tag, "_dbz"},  int'(bus.dbz), ez);
  endtask

  initial begin
    int lat, nbusy, bad, ndone, nb;
    int pairs[256];
    logic [3:0] hq, hr;

    tbl[0]  = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
    tbl[1]  = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1};
    tbl[2]  = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
    tbl[3]  = '{4'd2,  4'd5,  4'd0,  4'd2, 1'b0};
    tbl[4]  = '{4'd9,  4'd2,  4'd4,  4'd1, 1'b0};
    tbl[5]  = '{4'd12, 4'd5,  4'd2,  4'd2, 1'b0};
    tbl[6]  = '{4'd0,  4'd7,  4'd0,  4'd0, 1'b0};
    tbl[7]  = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
    tbl[8]  = '{4'd8,  4'd8,  4'd1,  4'd0, 1'b0};
    tbl[9]  = '{4'd14, 4'd4,  4'd3,  4'd2, 1'b0};
    tbl[10] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0};
    tbl[11] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1};

    rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0;
    #1;
    chk("rst_q",    int'(bus.Q),    0);
    chk("rst_r",    int'(bus.R),    0);
    chk("rst_dbz",  int'(bus.dbz),  0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed table; the first entry starts right after reset release.
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, lat, nbusy, bad);
      chk($sformatf("tbl%0d_lat", i),  lat,           tbl[i].b == 0 ? 1 : 5);
      chk($sformatf("tbl%0d_busy", i), nbusy,         tbl[i].b == 0 ? 0 : 4);
      chk($sformatf("tbl%0d_hold", i), bad,           0);
      chk($sformatf("tbl%0d_q", i),    int'(bus.Q),   int'(tbl[i].q));
      chk($sformatf("tbl%0d_r", i),    int'(bus.R),   int'(tbl[i].r));
      chk($sformatf("tbl%0d_dbz", i),  int'(bus.dbz), int'(tbl[i].z));
      @(negedge clk);
      chk($sformatf("tbl%0d_idle", i), int'(bus.done), 0);
    end

    // Held start: second operation accepted in the DONE cycle.
    hq = bus.Q; hr = bus.R;
    bus.start = 1'b1; bus.A = 4'd15; bus.B = 4'd1;
    @(negedge clk);
    bus.A = 4'd2; bus.B = 4'd5;
    wait_done(hq, hr, bus.dbz, lat, nbusy, bad);
    chk("b2b1_lat", lat, 5);
    chk("b2b1_q", int'(bus.Q), 15);
    chk("b2b1_r", int'(bus.R), 0);
    @(negedge clk);
    chk("b2b2_busy", int'(bus.busy), 1);
    bus.start = 1'b0;
    wait_done(4'd15, 4'd0, 1'b0, lat, nbusy, bad);
    chk("b2b2_lat", lat, 5);
    chk("b2b2_hold", bad, 0);
    chk("b2b2_q", int'(bus.Q), 0);
    chk("b2b2_r", int'(bus.R), 2);
    @(negedge clk);

    // Start and operand changes during RUN are ignored.
    hq = bus.Q; hr = bus.R;
    bus.start = 1'b1; bus.A = 4'd9; bus.B = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.A = 4'd15; bus.B = 4'd15;
    @(negedge clk);
    bus.start = 1'b0; bus.A = 4'd3; bus.B = 4'd1;
    wait_done(hq, hr, 1'b0, lat, nbusy, bad);
    chk("ign_lat", lat, 3);
    chk("ign_hold", bad, 0);
    chk("ign_q", int'(bus.Q), 4);
    chk("ign_r", int'(bus.R), 1);
    @(negedge clk);

    // Reset in the second RUN cycle aborts the operation immediately.
    bus.start = 1'b1; bus.A = 4'd12; bus.B = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("abort_pre_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_q",    int'(bus.Q),    0);
    chk("abort_r",    int'(bus.R),    0);
    chk("abort_dbz",  int'(bus.dbz),  0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    ndone = 0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.busy) nb++;
    end
    chk("abort_nodone", ndone, 0);
    chk("abort_nobusy", nb, 0);
    run_check("fresh", 4'd12, 4'd5);
    @(negedge clk);

    // Every operand pair, shuffled, mostly back-to-back.
    for (int i = 0; i < 256; i++) pairs[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = pairs[i]; pairs[i] = pairs[j]; pairs[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a, b;
      a = 4'(pairs[i] >> 4);
      b = 4'(pairs[i]);
      run_check($sformatf("rnd_a%0d_b%0d", a, b), a, b);
      if ($urandom_range(0, 3) == 0) begin
        hq = bus.Q;
        @(negedge clk);
        chk("rnd_gap_done", int'(bus.done), 0);
        chk("rnd_gap_q", int'(bus.Q), int'(hq));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
